// File: rtl/shift_align_stage.sv
// Two-stage exponent compare/swap and mantissa alignment stage with valid/ready flow control.
// Optional SHIFT_ALIGN_STICKY_EN folds the OR of shifted-out bits into bit 0 of mantis_aligned.
module shift_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_A,
  input  logic [EXP_W-1:0] exp_B,
  input  logic [MAN_W-1:0] mantis_A,
  input  logic [MAN_W-1:0] mantis_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             comp_code,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic [MAN_W-1:0] mantis_aligned,
  output logic [EXP_W-1:0] exp_diff
);

  function automatic logic [MAN_W-1:0] align_shift(input logic [MAN_W-1:0] m,
                                                   input logic [EXP_W-1:0] d);
    logic [MAN_W-1:0] sh;
    logic             sticky;
    if (32'(d) >= 32'(MAN_W)) begin
      sh     = '0;
      sticky = |m;
    end else begin
      sh     = m >> d;
      sticky = |(m & ~({MAN_W{1'b1}} << d));
    end
`ifdef SHIFT_ALIGN_STICKY_EN
    sh[0] = sh[0] | sticky;
`else
    sticky = 1'b0;
    sh[0]  = sh[0] | sticky;
`endif
    return sh;
  endfunction

  logic             s1_vld_q;
  logic             s1_comp_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [EXP_W-1:0] s1_diff_q;
  logic [MAN_W-1:0] s1_big_q;
  logic [MAN_W-1:0] s1_small_q;
  logic             s2_vld_q;

  logic             s2_adv;
  logic             s1_comp_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [EXP_W-1:0] s1_diff_d;
  logic [MAN_W-1:0] s1_big_d;
  logic [MAN_W-1:0] s1_small_d;
  logic [MAN_W-1:0] s2_aligned_d;

  // S2 frees up when empty or consumed; S1 moves on exactly when S2 advances.
  assign s2_adv    = !s2_vld_q || out_ready;
  assign in_ready  = !s1_vld_q || s2_adv;
  assign out_valid = s2_vld_q;

  always_comb begin
    s1_comp_d = (exp_A > exp_B) || ((exp_A == exp_B) && (mantis_A >= mantis_B));
    if (s1_comp_d) begin
      s1_exp_d   = exp_A;
      s1_diff_d  = exp_A - exp_B;
      s1_big_d   = mantis_A;
      s1_small_d = mantis_B;
    end else begin
      s1_exp_d   = exp_B;
      s1_diff_d  = exp_B - exp_A;
      s1_big_d   = mantis_B;
      s1_small_d = mantis_A;
    end
    s2_aligned_d = align_shift(s1_small_q, s1_diff_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      if (in_ready) s1_vld_q <= in_valid;
      if (s2_adv)   s2_vld_q <= s1_vld_q;
    end
  end

  // S1: compare/swap result
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_comp_q  <= s1_comp_d;
      s1_exp_q   <= s1_exp_d;
      s1_diff_q  <= s1_diff_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
    end
  end

  // S2: aligned result, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_code      <= 1'b0;
      exp_out        <= '0;
      mantis_out     <= '0;
      mantis_aligned <= '0;
      exp_diff       <= '0;
    end else if (s2_adv && s1_vld_q) begin
      comp_code      <= s1_comp_q;
      exp_out        <= s1_exp_q;
      mantis_out     <= s1_big_q;
      mantis_aligned <= s2_aligned_d;
      exp_diff       <= s1_diff_q;
    end
  end

endmodule

// File: tb/tb_shift_align_stage.sv
// Randomized bench for shift_align_stage against a queue-based reference model.
module tb_shift_align_stage;
  localparam int EW = 8;
  localparam int MW = 26;

  typedef struct {
    logic          comp;
    logic [EW-1:0] ex;
    logic [MW-1:0] man;
    logic [MW-1:0] al;
    logic [EW-1:0] diff;
    int            t;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] exp_A = '0, exp_B = '0;
  logic [MW-1:0] mantis_A = '0, mantis_B = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          comp_code;
  logic [EW-1:0] exp_out, exp_diff;
  logic [MW-1:0] mantis_out, mantis_aligned;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  res_t q[$];

  shift_align_stage #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_A(exp_A), .exp_B(exp_B), .mantis_A(mantis_A), .mantis_B(mantis_B),
    .out_valid(out_valid), .out_ready(out_ready), .comp_code(comp_code),
    .exp_out(exp_out), .mantis_out(mantis_out), .mantis_aligned(mantis_aligned),
    .exp_diff(exp_diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, expv, $time);
    end
  endtask

  function automatic res_t model(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                 input logic [MW-1:0] ma, input logic [MW-1:0] mb);
    res_t   r;
    int     d;
    longint sm, sh;
    logic   sticky;
    r.comp = (ea > eb) || (ea == eb && ma >= mb);
    r.ex   = r.comp ? ea : eb;
    r.man  = r.comp ? ma : mb;
    sm     = r.comp ? longint'(mb) : longint'(ma);
    d      = r.comp ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
    r.diff = EW'(d);
    if (d >= MW) begin
      sh = 0;
      sticky = (sm != 0);
    end else begin
      sh = sm >> d;
      sticky = ((sm - (sh << d)) != 0);
    end
`ifdef SHIFT_ALIGN_STICKY_EN
    if (sticky) sh = sh | 1;
`endif
    r.al = MW'(sh);
    r.t  = 0;
    return r;
  endfunction

  // Per-cycle compare at the falling edge; also books the handshakes of the coming rising edge.
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    res_t r;
    cyc++;
    if (rst) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_fields", {comp_code, exp_out, mantis_out, mantis_aligned, exp_diff}, 0);
      q.delete();
    end else begin
      exp_rdy = (q.size() < 2) || out_ready;
      exp_ov  = (q.size() > 0) && (cyc - q[0].t >= 2);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov && out_valid) begin
        chk("comp_code", comp_code, q[0].comp);
        chk("exp_out", exp_out, q[0].ex);
        chk("mantis_out", mantis_out, q[0].man);
        chk("mantis_aligned", mantis_aligned, q[0].al);
        chk("exp_diff", exp_diff, q[0].diff);
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        r = model(exp_A, exp_B, mantis_A, mantis_B);
        r.t = cyc;
        q.push_back(r);
      end
    end
  end

  task automatic drive(input logic v, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                       input logic [MW-1:0] ma, input logic [MW-1:0] mb, input logic ordy);
    @(posedge clk);
    #1;
    in_valid = v; exp_A = ea; exp_B = eb; mantis_A = ma; mantis_B = mb; out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  // Single pair on an empty pipe; result must be on the outputs two edges after acceptance.
  task automatic directed(input string name, input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                          input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                          input logic cc, input logic [EW-1:0] dd, input logic [MW-1:0] al);
    drive(1'b1, ea, eb, ma, mb, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_comp"}, comp_code, cc);
    chk({name, "_diff"}, exp_diff, dd);
    chk({name, "_aligned"}, mantis_aligned, al);
  endtask

  initial begin
    res_t r;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic [MW-1:0] al20, al21;
    int guard;

`ifdef SHIFT_ALIGN_STICKY_EN
    al20 = 26'h0000003;
    al21 = 26'h0000001;
`else
    al20 = 26'h0000002;
    al21 = 26'h0000000;
`endif

    // Literal pins on the model itself
    r = model(8'h85, 8'h82, 26'h3000000, 26'h2000000);
    chk("pin19_comp", r.comp, 1);
    chk("pin19_exp", r.ex, 8'h85);
    chk("pin19_diff", r.diff, 3);
    chk("pin19_al", r.al, 26'h0400000);
    r = model(8'h10, 8'h12, 26'h000000A, 26'h0);
    chk("pin20_comp", r.comp, 0);
    chk("pin20_al", r.al, al20);
    r = model(8'h40, 8'h22, 26'h1000000, 26'h0000001);
    chk("pin21_diff", r.diff, 30);
    chk("pin21_al", r.al, al21);
    r = model(8'h7F, 8'h7F, 26'h1234567, 26'h1234567);
    chk("pin24_al", r.al, 26'h1234567);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);

    directed("d19", 8'h85, 8'h82, 26'h3000000, 26'h2000000, 1'b1, 8'd3, 26'h0400000);
    chk("d19_exp", exp_out, 8'h85);
    idle(2);
    directed("d20", 8'h10, 8'h12, 26'h000000A, 26'h0, 1'b0, 8'd2, al20);
    idle(2);
    directed("d21", 8'h40, 8'h22, 26'h1000000, 26'h0000001, 1'b1, 8'd30, al21);
    idle(2);
    directed("d24", 8'h7F, 8'h7F, 26'h1234567, 26'h1234567, 1'b1, 8'd0, 26'h1234567);
    idle(2);

    // Three back-to-back offers into a stalled output, then release
    drive(1'b1, 8'h20, 8'h1C, 26'h0ABCDEF, 26'h3FFFFFF, 1'b0);
    drive(1'b1, 8'h05, 8'h09, 26'h1111111, 26'h2222222, 1'b0);
    drive(1'b1, 8'h33, 8'h33, 26'h0000010, 26'h0000020, 1'b0);
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(4);

    // Reset while two pairs are in flight
    drive(1'b1, 8'h50, 8'h40, 26'h0FFFFFF, 26'h0F0F0F0, 1'b0);
    drive(1'b1, 8'h41, 8'h42, 26'h0123456, 26'h0654321, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_fields", {comp_code, exp_out, mantis_out, mantis_aligned, exp_diff}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed("post_rst", 8'h85, 8'h82, 26'h3000000, 26'h2000000, 1'b1, 8'd3, 26'h0400000);
    idle(2);

    // Random traffic: first with out_ready high, then with random backpressure
    for (int i = 0; i < 600; i++) begin
      ea = EW'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? ea : ($urandom_range(0, 1) ? EW'($urandom) : EW'(ea + $urandom_range(0, 6)));
      ma = MW'($urandom);
      mb = ($urandom_range(0, 7) == 0) ? ma : MW'($urandom);
      drive(($urandom_range(0, 9) < 8), ea, eb, ma, mb,
            (i < 150) ? 1'b1 : ($urandom_range(0, 2) != 0));
    end

    drive(1'b0, '0, '0, '0, '0, 1'b1);
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_align_stage.md
SHIFT_ALIGN_STAGE -- requirements
Module: shift_align_stage

Interface
REQ-001 Parameter EXP_W, default 8: exponent width in bits; SHALL be >= 2.
REQ-002 Parameter MAN_W, default 26: mantissa width in bits, including guard bits; SHALL be >= 4.
REQ-003 Ports SHALL be as follows, clock and reset first:
  clk            in   1      sole clock; all state changes on the rising edge
  rst            in   1      asynchronous, active-high reset
  in_valid       in   1      operand pair on exp_A/exp_B/mantis_A/mantis_B is valid
  in_ready       out  1      stage can accept a pair this cycle
  exp_A          in   EXP_W  operand A exponent
  exp_B          in   EXP_W  operand B exponent
  mantis_A       in   MAN_W  operand A mantissa
  mantis_B       in   MAN_W  operand B mantissa
  out_valid      out  1      result fields are valid
  out_ready      in   1      downstream accepts the result this cycle
  comp_code      out  1      1: A is the larger operand; 0: B is the larger operand
  exp_out        out  EXP_W  exponent of the larger operand
  mantis_out     out  MAN_W  mantissa of the larger operand, unshifted
  mantis_aligned out  MAN_W  mantissa of the smaller operand, right-shifted by exp_diff
  exp_diff       out  EXP_W  exp_out minus the smaller exponent, unsigned

Function
REQ-004 A transfer occurs on a clock edge where in_valid=1 and in_ready=1; a result is consumed on an edge where out_valid=1 and out_ready=1.
REQ-005 The datapath SHALL be a 2-stage pipeline: S1 registers the compare/swap result, S2 registers the aligned result; latency SHALL be 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-006 Compare rule: comp_code=1 if exp_A>exp_B, or if exp_A==exp_B and mantis_A>=mantis_B; otherwise comp_code=0.
REQ-007 S1 SHALL capture the larger exponent and mantissa, the smaller mantissa, exp_diff (computed without a borrow), and comp_code.
REQ-008 S2 SHALL compute mantis_aligned = smaller mantissa >> exp_diff; if exp_diff>=MAN_W, the shifted value SHALL be 0.
REQ-009 Each stage SHALL advance when it is empty or when the stage downstream of it advances in the same cycle; S2 advances when it is consumed.
REQ-010 in_ready SHALL equal NOT S1.valid OR S1 advancing; this is a combinational function of out_ready and stage state, with no combinational path from in_valid.
REQ-011 With out_ready held high, the stage SHALL sustain 1 transfer per cycle with no bubbles.
REQ-012 With out_ready low, output fields SHALL remain stable while out_valid=1; at most 2 pairs are held; no pair is lost or reordered.
REQ-013 When a result is consumed and a new pair is accepted in the same cycle, both actions SHALL take effect with no stall.
REQ-014 Equal operands (same exponent and mantissa) SHALL give comp_code=1, exp_diff=0, and mantis_aligned=mantis_B.

Reset
REQ-015 While rst=1: S1 and S2 valid flags, out_valid, comp_code, exp_out, mantis_out, mantis_aligned and exp_diff SHALL all be 0; in_ready SHALL be 1 after release.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight pairs immediately, asynchronously to clk; no result from before reset SHALL appear after reset.

Configuration
REQ-017 Macro SHIFT_ALIGN_STICKY_EN: when defined, bit 0 of mantis_aligned SHALL be the shifted LSB ORed with the OR of all bits shifted out; for exp_diff>=MAN_W it SHALL be the OR of the entire smaller mantissa.
REQ-018 When SHIFT_ALIGN_STICKY_EN is undefined, shifted-out bits SHALL be discarded (plain truncation), per REQ-008.

Verification (MAN_W=26, EXP_W=8)
REQ-019 exp_A=8'h85, mantis_A=26'h3000000, exp_B=8'h82, mantis_B=26'h2000000, out_ready=1 -> 2 cycles later: comp_code=1, exp_out=8'h85, exp_diff=3, mantis_aligned=26'h0400000.
REQ-020 exp_A=8'h10, exp_B=8'h12, mantis_A=26'h000000A -> comp_code=0, exp_diff=2, mantis_aligned=26'h0000002 without the macro, 26'h0000003 with it.
REQ-021 exp_A=8'h40, exp_B=8'h22, mantis_B=26'h0000001 (exp_diff=30) -> mantis_aligned=0 without the macro, 26'h0000001 with it.
REQ-022 Offer 3 back-to-back pairs with out_ready=0 for 4 cycles, then out_ready=1 -> 2 pairs accepted, in_ready=0 until a result is consumed, all 3 results emerge in order with stable fields.
REQ-023 Assert rst for 1 cycle while 2 pairs are in flight -> out_valid=0 and all outputs 0 immediately; the next accepted pair returns correctly 2 cycles after acceptance.
REQ-024 exp_A=exp_B=8'h7F, mantis_A=mantis_B=26'h1234567 -> comp_code=1, exp_diff=0, mantis_aligned=26'h1234567.
